// File: rtl/operand_sequencer.sv
// operand_sequencer: captures one A row and one B column (DEPTH elements of
// DATA_W bits each) on start, then streams them pair by pair to the MAC stage
// under a valid/ready handshake and pulses done after the last transfer.
// Optional build macro OPSEQ_ZERO_IDLE_EN: when defined, a_out/b_out read 0
// whenever out_valid is low; otherwise they hold the last streamed pair.
module operand_sequencer #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DEPTH*DATA_W-1:0] a_vec,
    input  logic [DEPTH*DATA_W-1:0] b_vec,
    output logic [DATA_W-1:0]       a_out,
    output logic [DATA_W-1:0]       b_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   idx_nxt;
    logic               last;
    logic               xfer;

    // unpacked views of the input vectors and the captured copies
    logic [DATA_W-1:0]  a_elem [DEPTH];
    logic [DATA_W-1:0]  b_elem [DEPTH];
    logic [DATA_W-1:0]  sh_a   [DEPTH];
    logic [DATA_W-1:0]  sh_b   [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
        assign a_elem[k] = a_vec[k*DATA_W +: DATA_W];
        assign b_elem[k] = b_vec[k*DATA_W +: DATA_W];
    end

    // idx_nxt is only used when idx < DEPTH-1, so it always fits in CNT_W
    assign idx_nxt = idx + 1'b1;
    assign last    = (idx == CNT_W'(DEPTH - 1));
    assign xfer    = out_valid & out_ready;

    // control FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sh_a[k] <= '0;
                sh_b[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // snapshot so later input changes cannot disturb the stream
                        sh_a      <= a_elem;
                        sh_b      <= b_elem;
                        idx       <= '0;
                        a_out     <= a_elem[0];
                        b_out     <= b_elem[0];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
`ifdef OPSEQ_ZERO_IDLE_EN
                            a_out     <= '0;
                            b_out     <= '0;
`else
                            a_out     <= a_out;
                            b_out     <= b_out;
`endif
                        end else begin
                            idx   <= idx_nxt;
                            a_out <= sh_a[idx_nxt];
                            b_out <= sh_b[idx_nxt];
                        end
                    end
                end
                DONE: begin
                    // start here is dropped, not queued
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: a DEPTH=4/8-bit instance for the
// handshake scenarios and a DEPTH=7/16-bit instance for the parametrised build.
module tb_operand_sequencer;

    logic        clk;
    logic        reset;
    // 4 x 8-bit instance
    logic        start;
    logic [31:0] a_vec, b_vec;
    logic [7:0]  a_out, b_out;
    logic        out_valid, out_ready, busy, done;
    // 7 x 16-bit instance
    logic         start7;
    logic [111:0] a_vec7, b_vec7;
    logic [15:0]  a_out7, b_out7;
    logic         out_valid7, out_ready7, busy7, done7;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ea [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] eb [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

`ifdef OPSEQ_ZERO_IDLE_EN
    localparam logic [7:0] IDLE_A = 8'h00;
    localparam logic [7:0] IDLE_B = 8'h00;
`else
    localparam logic [7:0] IDLE_A = 8'h44;
    localparam logic [7:0] IDLE_B = 8'hD4;
`endif

    operand_sequencer #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_vec(a_vec), .b_vec(b_vec),
        .a_out(a_out), .b_out(b_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    operand_sequencer #(.DATA_W(16), .DEPTH(7)) dut7 (
        .clk(clk), .reset(reset), .start(start7),
        .a_vec(a_vec7), .b_vec(b_vec7),
        .a_out(a_out7), .b_out(b_out7),
        .out_valid(out_valid7), .out_ready(out_ready7),
        .busy(busy7), .done(done7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge and settle away from it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({out_valid, busy, done, a_out, b_out} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b b=%b d=%b a=%h b=%h, want all 0",
                     out_valid, busy, done, a_out, b_out);
        end
        n_cmp++;
        if ({out_valid7, busy7, done7, a_out7, b_out7} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_state7: got v=%b b=%b d=%b a=%h b=%h, want all 0",
                     out_valid7, busy7, done7, a_out7, b_out7);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        a_vec = 32'h44332211;
        b_vec = 32'hD4C3B2A1;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({out_valid, busy, done, a_out, b_out} !== {3'b110, ea[i], eb[i]}) begin
                n_err++;
                $display("FAIL basic_pair%0d: got v=%b b=%b d=%b a=%h b=%h, want v=1 b=1 d=0 a=%h b=%h",
                         i, out_valid, busy, done, a_out, b_out, ea[i], eb[i]);
            end
            tick();
        end
        n_cmp++;
        if ({out_valid, busy, done} !== 3'b011) begin
            n_err++;
            $display("FAIL basic_done: got v=%b b=%b d=%b, want v=0 b=1 d=1", out_valid, busy, done);
        end
        tick();
        n_cmp++;
        if ({out_valid, busy, done, a_out, b_out} !== {3'b000, IDLE_A, IDLE_B}) begin
            n_err++;
            $display("FAIL basic_idle: got v=%b b=%b d=%b a=%h b=%h, want 0 0 0 a=%h b=%h",
                     out_valid, busy, done, a_out, b_out, IDLE_A, IDLE_B);
        end
    endtask

    task automatic test_backpressure;
        logic       rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int         eidx [6] = '{0, 1, 1, 1, 2, 3};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            out_ready = rdy[c];
            n_cmp++;
            if ({out_valid, busy, done, a_out, b_out} !== {3'b110, ea[eidx[c]], eb[eidx[c]]}) begin
                n_err++;
                $display("FAIL bp_cycle%0d: got v=%b d=%b a=%h b=%h, want v=1 d=0 a=%h b=%h",
                         c, out_valid, done, a_out, b_out, ea[eidx[c]], eb[eidx[c]]);
            end
            tick();
        end
        n_cmp++;
        if ({out_valid, busy, done} !== 3'b011) begin
            n_err++;
            $display("FAIL bp_done: got v=%b b=%b d=%b, want v=0 b=1 d=1", out_valid, busy, done);
        end
        tick();
        out_ready = 1'b1;
        n_cmp++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL bp_idle: got v=%b b=%b d=%b, want 0 0 0", out_valid, busy, done);
        end
    endtask

    task automatic test_ignored_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) a_vec = 32'hDEADBEEF;
            start = (i == 1);
            n_cmp++;
            if ({out_valid, busy, done, a_out, b_out} !== {3'b110, ea[i], eb[i]}) begin
                n_err++;
                $display("FAIL iso_pair%0d: got v=%b d=%b a=%h b=%h, want v=1 d=0 a=%h b=%h",
                         i, out_valid, done, a_out, b_out, ea[i], eb[i]);
            end
            tick();
        end
        start = 1'b1;
        n_cmp++;
        if ({out_valid, done} !== 2'b01) begin
            n_err++;
            $display("FAIL iso_done: got v=%b d=%b, want v=0 d=1", out_valid, done);
        end
        tick();
        start = 1'b0;
        n_cmp++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL iso_no_restart: got v=%b b=%b d=%b, want 0 0 0", out_valid, busy, done);
        end
        tick();
        n_cmp++;
        if ({out_valid, busy, done, a_out} !== {3'b000, IDLE_A}) begin
            n_err++;
            $display("FAIL iso_still_idle: got v=%b b=%b d=%b a=%h, want 0 0 0 a=%h",
                     out_valid, busy, done, a_out, IDLE_A);
        end
        a_vec = 32'h44332211;
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if ({out_valid, a_out, b_out} !== {1'b1, ea[1], eb[1]}) begin
            n_err++;
            $display("FAIL rst_pre: got v=%b a=%h b=%h, want v=1 a=%h b=%h",
                     out_valid, a_out, b_out, ea[1], eb[1]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if ({out_valid, busy, done, a_out, b_out} !== 19'd0) begin
                n_err++;
                $display("FAIL rst_abort%0d: got v=%b b=%b d=%b a=%h b=%h, want all 0",
                         c, out_valid, busy, done, a_out, b_out);
            end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({out_valid, busy, done, a_out, b_out} !== {3'b110, ea[i], eb[i]}) begin
                n_err++;
                $display("FAIL rst_restart_pair%0d: got v=%b d=%b a=%h b=%h, want v=1 d=0 a=%h b=%h",
                         i, out_valid, done, a_out, b_out, ea[i], eb[i]);
            end
            tick();
        end
        n_cmp++;
        if ({out_valid, busy, done} !== 3'b011) begin
            n_err++;
            $display("FAIL rst_restart_done: got v=%b b=%b d=%b, want v=0 b=1 d=1", out_valid, busy, done);
        end
        tick();
    endtask

    task automatic test_param;
        for (int k = 0; k < 7; k++) begin
            a_vec7[k*16 +: 16] = 16'h0100 + 16'(k);
            b_vec7[k*16 +: 16] = 16'h0200 + 16'(k);
        end
        out_ready7 = 1'b1;
        start7 = 1'b1;
        tick();
        start7 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if ({out_valid7, busy7, done7, a_out7, b_out7} !==
                {3'b110, 16'h0100 + 16'(i), 16'h0200 + 16'(i)}) begin
                n_err++;
                $display("FAIL p7_pair%0d: got v=%b d=%b a=%h b=%h, want v=1 d=0 a=%h b=%h",
                         i, out_valid7, done7, a_out7, b_out7, 16'h0100 + 16'(i), 16'h0200 + 16'(i));
            end
            tick();
        end
        n_cmp++;
        if ({out_valid7, busy7, done7} !== 3'b011) begin
            n_err++;
            $display("FAIL p7_done: got v=%b b=%b d=%b, want v=0 b=1 d=1", out_valid7, busy7, done7);
        end
        tick();
        n_cmp++;
        if ({out_valid7, busy7, done7} !== 3'b000) begin
            n_err++;
            $display("FAIL p7_idle: got v=%b b=%b d=%b, want 0 0 0", out_valid7, busy7, done7);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a_vec = '0;
        b_vec = '0;
        out_ready = 1'b1;
        start7 = 1'b0;
        a_vec7 = '0;
        b_vec7 = '0;
        out_ready7 = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Parametrised operand feeder for the matrix multiply datapath. Captures one row of A and one column of B, each `DEPTH` elements of `DATA_W` bits, on a `start` pulse. Streams them element-pair by element-pair into the MAC/systolic stage under a valid/ready handshake, then signals `done`. Successor to the fixed 4×8-bit free-running feeder; adds parametrised width and depth, start/busy/done control and backpressure.

## Interface
- `DATA_W`, default 8: element width in bits.
- `DEPTH`, default 4: elements per operand vector; must be ≥ 2.
- `CNT_W`, default `$clog2(DEPTH)`: index counter width; derived, not overridden.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request a new stream; sampled only in IDLE.
- `a_vec` input DEPTH*DATA_W: A operands; element k is `a_vec[k*DATA_W +: DATA_W]`.
- `b_vec` input DEPTH*DATA_W: B operands; same packing as `a_vec`.
- `a_out` output DATA_W: current A element.
- `b_out` output DATA_W: current B element.
- `out_valid` output 1: `a_out`/`b_out` hold a valid pair.
- `out_ready` input 1: consumer accepts the pair this cycle.
- `busy` output 1: high in STREAM and DONE.
- `done` output 1: one-cycle pulse after the last pair transfers.

## Operation
- States: IDLE, STREAM, DONE.
- IDLE, `start`=1:
  - register `a_vec`/`b_vec` into internal shadow registers;
  - set index to 0 and go to STREAM.
- IDLE, `start`=0: remain in IDLE.
- STREAM:
  - `out_valid`=1; `a_out`/`b_out` = shadow element at the current index.
  - Transfer = `out_valid && out_ready`.
  - On a transfer with index < DEPTH-1: index increments.
  - On a transfer with index = DEPTH-1: go to DONE.
  - No transfer: index, `a_out`, `b_out` held stable.
- DONE: `done`=1 and `out_valid`=0 for exactly one cycle, then IDLE unconditionally.
- `start` outside IDLE is ignored, including in DONE; it is not queued.
- Changes on `a_vec`/`b_vec` after capture do not affect the stream in progress.
- The index never exceeds DEPTH-1; there is no wrap to a second pass.
- Elements leave in index order 0..DEPTH-1; A and B always share the same index.
- `reset`: state IDLE, index 0, `out_valid`/`busy`/`done` = 0, `a_out`/`b_out` = 0, shadow registers = 0.
- `reset` mid-stream aborts it: no `done` pulse and no further valid pairs.
- `reset` and `start` in the same cycle: `reset` wins.

## Timing
- `start` sampled at edge T → first pair with `out_valid`=1 at T+1 (1-cycle latency).
- With `out_ready` held high: DEPTH consecutive valid cycles, T+1..T+DEPTH; `done` at T+DEPTH+1; IDLE at T+DEPTH+2.
- Earliest next accepted `start` is sampled at edge T+DEPTH+2.
- Every stall cycle (`out_ready`=0 while valid) adds exactly one cycle to the sequence.
- `busy` = 1 from T+1 through the `done` cycle inclusive.
- All outputs are registered; there is no combinational path from `out_ready` or `start` to any output.

## Configuration
- `OPSEQ_ZERO_IDLE_EN` defined: `a_out`/`b_out` are driven to 0 in every cycle `out_valid`=0 (IDLE, DONE).
- `OPSEQ_ZERO_IDLE_EN` undefined:
  - `a_out`/`b_out` hold the last streamed pair after the stream ends;
  - they read 0 only after `reset`, until the first stream.
- Handshake, state and timing behaviour is identical in both builds.

## Test plan
- Basic stream: DEPTH=4, DATA_W=8, `a_vec` elements {0x11,0x22,0x33,0x44}, `b_vec` {0xA1,0xB2,0xC3,0xD4}, `out_ready`=1, `start` at T → pairs (11,A1),(22,B2),(33,C3),(44,D4) at T+1..T+4; `done` at T+5 only; `busy` high T+1..T+5.
- Backpressure: same vectors, `out_ready`=0 on T+2 and T+3 → (22,B2) held 3 cycles T+2..T+4; `done` at T+7; no pair skipped or duplicated beyond the hold.
- Ignored start and capture isolation:
  - `start` pulsed at T+2 and in the `done` cycle → no restart;
  - `a_vec` changed at T+1 → streamed values unchanged.
- Reset mid-stream: `reset` at T+2 → from T+3, `out_valid`/`busy`/`done` = 0 and `a_out`/`b_out` = 0; no `done` pulse; a new `start` afterwards streams normally.
- Parametrised build: DEPTH=7, DATA_W=16, elements 0x0100+k → 7 pairs in order, last pair 0x0106, `done` at T+8.
- Macro check: after the basic stream, in the IDLE cycle → `a_out`=0x00 with `OPSEQ_ZERO_IDLE_EN` defined, 0x44 with it undefined.
